lab2_proc_bypass_scoreboard: RTL and testbench
==============================================

// Module: lab2_proc_bypass_scoreboard
// PURPOSE
//  Hazard/bypass controller for the 5-stage pipelined TinyRV2 datapath.
//  Tracks destination-register info for instructions in X, M and W.
//  Per cycle, drives the D-stage op1/op2 bypass-mux selects, a RAW stall
//  request, and the W-stage regfile write controls.
//  Sits in the processor control unit next to the stage-valid logic.
// PARAMETERS
//  p_nregs      32  architectural registers (address width = $clog2)
//  p_stats_w    32  width of the optional statistics counters
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-low reset (0 = reset)
//  val_D            in   1   D holds a valid instruction
//  rs1_D / rs2_D    in   5   source register addresses
//  rs1_en_D/rs2_en_D in  1   source actually read
//  rd_D             in   5   destination address
//  rf_wen_D         in   1   instruction writes rd
//  wkind_D          in   2   result ready: 0=ALU/JAL/CSRR in X, 1=LOAD in M, 2=IMUL in X
//  issue_D          in   1   D instruction enters X this cycle
//  kill_X           in   1   X instruction squashed this cycle
//  adv_X/adv_M/adv_W in  1   X->M, M->W, W retires this cycle
//  imul_resp_val_X  in   1   multiplier response valid in X
//  op1_byp_sel_D    out  2   0=W 1=M 2=X 3=RF
//  op2_byp_sel_D    out  2   0=RF 1=W 2=M 3=X
//  stall_byp_D      out  1   RAW hazard cannot be bypassed; hold D
//  rf_waddr_W       out  5   regfile write address
//  rf_wen_W         out  1   regfile write enable
//  stall_cnt        out  p_stats_w  (only with macro) stall cycles
//  byp_cnt          out  p_stats_w  (only with macro) bypassed operands
// BEHAVIOUR
//  - State: three entries {val, wen, waddr, wkind} for X, M, W.
//  - Reset (async, while reset==0): all entries val=0.
//    Outputs during reset: op1 sel=3, op2 sel=0, stall=0, rf_wen_W=0,
//    rf_waddr_W=0, counters=0.
//  - Entry update on posedge clk:
//    - X <= issue_D ? D fields : (adv_X | kill_X) ? invalid : hold.
//    - M <= adv_X & !kill_X ? X : adv_M ? invalid : hold.
//    - W <= adv_M ? M : adv_W ? invalid : hold.
//  - issue_D & kill_X together: the old X is killed, the new D is loaded.
//  - Operand match: src_en & src!=0 & entry.val & entry.wen & entry.waddr==src.
//  - Priority per operand: X, then M, then W, then RF (youngest wins).
//    - X match, wkind ALU: select X.
//    - X match, wkind LOAD: stall.
//    - X match, wkind IMUL: select X if imul_resp_val_X, else stall.
//    - M match (any kind): select M.
//    - W match: select W (covers same-cycle regfile write).
//    - Otherwise: select RF.
//  - stall_byp_D = val_D & (op1 stall | op2 stall). It is combinational,
//    so selection is zero-latency and same-cycle.
//  - When stall_byp_D=1, the select outputs keep the non-stall encoding;
//    the datapath ignores them.
//  - Register x0 never matches, never stalls and always selects RF.
//  - rf_wen_W = W.val & W.wen; rf_waddr_W = W.waddr (0 when !W.val).
// CONFIGURATION
//  - Macro LAB2_PROC_SCOREBOARD_STATS_EN enables the statistics counters.
//  - With the macro defined:
//    - stall_cnt += 1 each cycle stall_byp_D=1.
//    - byp_cnt += number of operands (0..2) selected from X/M/W on cycles
//      where issue_D=1.
//    - Both counters wrap modulo 2^p_stats_w.
//  - Without the macro, the counter ports and logic are absent. All other
//    behaviour is identical.
// STRUCTURE
//  - Package lab2_proc_sb_pkg holds:
//    - typedef sb_entry_t {val, wen, waddr[4:0], wkind[1:0]}.
//    - wkind constants WK_ALU=0, WK_LOAD=1, WK_IMUL=2.
//    - op1/op2 select-encoding constants.
//  - Sub-module lab2_proc_sb_src_sel (one source operand against the X/M/W
//    entries, returning {stall, src}) is instantiated twice. The top level
//    maps src to the op1/op2 encodings.
// TESTING
//  - Reset, then addi x1 issued; next D reads x1 (ALU in X) -> op1_sel=2,
//    stall=0.
//  - lw x2 in X; D add x3,x2,x2 -> stall=1. Then adv_X: lw in M ->
//    op1_sel=1, op2_sel=2, stall=0.
//  - mul x4 in X with imul_resp_val_X=0 -> stall=1. Set imul_resp_val_X=1
//    -> op2_sel=3, stall=0.
//  - x5 written in both M and W, D reads x5 -> M chosen (op1_sel=1).
//    rd=x0 in X, D reads x0 -> op1_sel=3.
//  - issue_D=1 with kill_X=1 on a branch: the killed rd=x6 never matches
//    later. W entry rd=7 valid -> rf_wen_W=1, rf_waddr_W=7.
//  - Assert reset mid-run with X/M/W all valid: outputs go to reset
//    values immediately (no clock edge). With the macro, counters read 0;
//    3 forced stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/lab2_proc_sb_pkg.sv
// Shared types and encodings for the TinyRV2 bypass/hazard scoreboard.
// Optional statistics counters are enabled with LAB2_PROC_SCOREBOARD_STATS_EN.
package lab2_proc_sb_pkg;

    localparam int SB_AW = 5;

    localparam logic [1:0] WK_ALU  = 2'd0;
    localparam logic [1:0] WK_LOAD = 2'd1;
    localparam logic [1:0] WK_IMUL = 2'd2;

    localparam logic [1:0] OP1_SEL_W  = 2'd0;
    localparam logic [1:0] OP1_SEL_M  = 2'd1;
    localparam logic [1:0] OP1_SEL_X  = 2'd2;
    localparam logic [1:0] OP1_SEL_RF = 2'd3;

    localparam logic [1:0] OP2_SEL_RF = 2'd0;
    localparam logic [1:0] OP2_SEL_W  = 2'd1;
    localparam logic [1:0] OP2_SEL_M  = 2'd2;
    localparam logic [1:0] OP2_SEL_X  = 2'd3;

    typedef struct packed {
        logic             val;
        logic             wen;
        logic [SB_AW-1:0] waddr;
        logic [1:0]       wkind;
    } sb_entry_t;

    // Stage that supplies an operand, independent of the op1/op2 mux encodings.
    typedef enum logic [1:0] {
        SRC_RF = 2'd0,
        SRC_X  = 2'd1,
        SRC_M  = 2'd2,
        SRC_W  = 2'd3
    } sb_src_e;

    function automatic logic [1:0] op1_enc(input sb_src_e s);
        case (s)
            SRC_X:   return OP1_SEL_X;
            SRC_M:   return OP1_SEL_M;
            SRC_W:   return OP1_SEL_W;
            default: return OP1_SEL_RF;
        endcase
    endfunction

    function automatic logic [1:0] op2_enc(input sb_src_e s);
        case (s)
            SRC_X:   return OP2_SEL_X;
            SRC_M:   return OP2_SEL_M;
            SRC_W:   return OP2_SEL_W;
            default: return OP2_SEL_RF;
        endcase
    endfunction

endpackage

// File: rtl/lab2_proc_sb_src_sel.sv
// Resolves one D-stage source operand against the X/M/W scoreboard entries,
// youngest first, returning the supplying stage and whether D must stall.
module lab2_proc_sb_src_sel
    import lab2_proc_sb_pkg::*;
(
    input  logic [SB_AW-1:0] src,
    input  logic             src_en,
    input  sb_entry_t        ent_x,
    input  sb_entry_t        ent_m,
    input  sb_entry_t        ent_w,
    input  logic             imul_resp_val_X,
    output logic             stall,
    output sb_src_e          sel
);

    logic w_live;
    logic w_hit_x;
    logic w_hit_m;
    logic w_hit_w;

    // x0 is hard-wired to zero, so it never depends on an in-flight writer.
    assign w_live  = src_en && (src != '0);
    assign w_hit_x = w_live && ent_x.val && ent_x.wen && (ent_x.waddr == src);
    assign w_hit_m = w_live && ent_m.val && ent_m.wen && (ent_m.waddr == src);
    assign w_hit_w = w_live && ent_w.val && ent_w.wen && (ent_w.waddr == src);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stall = 1'b0;
        sel   = SRC_RF;
        if (w_hit_x) begin
            sel = SRC_X;
            if (ent_x.wkind == WK_LOAD) begin
                stall = 1'b1;
            end else if (ent_x.wkind == WK_IMUL) begin
                stall = !imul_resp_val_X;
            end
        end else if (w_hit_m) begin
            sel = SRC_M;
        end else if (w_hit_w) begin
            sel = SRC_W;
        end
    end

endmodule

// File: rtl/lab2_proc_bypass_scoreboard.sv
// Hazard/bypass controller for the 5-stage TinyRV2 pipeline: tracks X/M/W writers,
// drives D-stage bypass selects, RAW stall and W-stage regfile write controls.
// Define LAB2_PROC_SCOREBOARD_STATS_EN to add the stall_cnt/byp_cnt statistics ports.
module lab2_proc_bypass_scoreboard
    import lab2_proc_sb_pkg::*;
#(
    parameter int p_nregs   = 32,
    parameter int p_stats_w = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       val_D,
    input  logic [$clog2(p_nregs)-1:0] rs1_D,
    input  logic [$clog2(p_nregs)-1:0] rs2_D,
    input  logic                       rs1_en_D,
    input  logic                       rs2_en_D,
    input  logic [$clog2(p_nregs)-1:0] rd_D,
    input  logic                       rf_wen_D,
    input  logic [1:0]                 wkind_D,
    input  logic                       issue_D,
    input  logic                       kill_X,
    input  logic                       adv_X,
    input  logic                       adv_M,
    input  logic                       adv_W,
    input  logic                       imul_resp_val_X,
    output logic [1:0]                 op1_byp_sel_D,
    output logic [1:0]                 op2_byp_sel_D,
    output logic                       stall_byp_D,
    output logic [$clog2(p_nregs)-1:0] rf_waddr_W,
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
    output logic [p_stats_w-1:0]       stall_cnt,
    output logic [p_stats_w-1:0]       byp_cnt,
`endif
    output logic                       rf_wen_W
);

    sb_entry_t r_ent_x;
    sb_entry_t r_ent_m;
    sb_entry_t r_ent_w;
    sb_entry_t w_ent_d;

    logic    w_op1_stall;
    logic    w_op2_stall;
    sb_src_e w_op1_src;
    sb_src_e w_op2_src;

    assign w_ent_d = '{val: val_D, wen: rf_wen_D, waddr: rd_D, wkind: wkind_D};

    // NOTE: sequential state uses non-blocking assignments so all three stages shift from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ent_x <= '0;
            r_ent_m <= '0;
            r_ent_w <= '0;
        end else begin
            // A same-cycle issue overrides kill: the old X is dropped, D is loaded.
            if (issue_D) begin
                r_ent_x <= w_ent_d;
            end else if (adv_X || kill_X) begin
                r_ent_x.val <= 1'b0;
            end

            if (adv_X && !kill_X) begin
                r_ent_m <= r_ent_x;
            end else if (adv_M) begin
                r_ent_m.val <= 1'b0;
            end

            if (adv_M) begin
                r_ent_w <= r_ent_m;
            end else if (adv_W) begin
                r_ent_w.val <= 1'b0;
            end
        end
    end

    lab2_proc_sb_src_sel u_op1_sel (
        .src             (rs1_D),
        .src_en          (rs1_en_D),
        .ent_x           (r_ent_x),
        .ent_m           (r_ent_m),
        .ent_w           (r_ent_w),
        .imul_resp_val_X (imul_resp_val_X),
        .stall           (w_op1_stall),
        .sel             (w_op1_src)
    );

    lab2_proc_sb_src_sel u_op2_sel (
        .src             (rs2_D),
        .src_en          (rs2_en_D),
        .ent_x           (r_ent_x),
        .ent_m           (r_ent_m),
        .ent_w           (r_ent_w),
        .imul_resp_val_X (imul_resp_val_X),
        .stall           (w_op2_stall),
        .sel             (w_op2_src)
    );

    assign op1_byp_sel_D = op1_enc(w_op1_src);
    assign op2_byp_sel_D = op2_enc(w_op2_src);
    assign stall_byp_D   = val_D && (w_op1_stall || w_op2_stall);

    assign rf_wen_W   = r_ent_w.val && r_ent_w.wen;
    assign rf_waddr_W = r_ent_w.val ? r_ent_w.waddr : '0;

`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
    logic [p_stats_w-1:0] r_stall_cnt;
    logic [p_stats_w-1:0] r_byp_cnt;
    logic [1:0]           w_byp_n;

    assign w_byp_n = {1'b0, w_op1_src != SRC_RF} + {1'b0, w_op2_src != SRC_RF};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_byp_cnt   <= '0;
        end else begin
            if (stall_byp_D) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (issue_D) begin
                r_byp_cnt <= r_byp_cnt + {{(p_stats_w-2){1'b0}}, w_byp_n};
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign byp_cnt   = r_byp_cnt;
`endif

endmodule

// File: tb/tb_lab2_proc_bypass_scoreboard.sv
// Scoreboard bench for lab2_proc_bypass_scoreboard: directed hazard scenarios then
// random traffic, checked against an in-order pipeline model (also covers LAB2_PROC_SCOREBOARD_STATS_EN).
module tb_lab2_proc_bypass_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       val_D;
    logic [4:0] rs1_D;
    logic [4:0] rs2_D;
    logic       rs1_en_D;
    logic       rs2_en_D;
    logic [4:0] rd_D;
    logic       rf_wen_D;
    logic [1:0] wkind_D;
    logic       issue_D;
    logic       kill_X;
    logic       adv_X;
    logic       adv_M;
    logic       adv_W;
    logic       imul_resp_val_X;
    logic [1:0] op1_byp_sel_D;
    logic [1:0] op2_byp_sel_D;
    logic       stall_byp_D;
    logic [4:0] rf_waddr_W;
    logic       rf_wen_W;
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] byp_cnt;
`endif

    always #5 clk = ~clk;

    lab2_proc_bypass_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .val_D           (val_D),
        .rs1_D           (rs1_D),
        .rs2_D           (rs2_D),
        .rs1_en_D        (rs1_en_D),
        .rs2_en_D        (rs2_en_D),
        .rd_D            (rd_D),
        .rf_wen_D        (rf_wen_D),
        .wkind_D         (wkind_D),
        .issue_D         (issue_D),
        .kill_X          (kill_X),
        .adv_X           (adv_X),
        .adv_M           (adv_M),
        .adv_W           (adv_W),
        .imul_resp_val_X (imul_resp_val_X),
        .op1_byp_sel_D   (op1_byp_sel_D),
        .op2_byp_sel_D   (op2_byp_sel_D),
        .stall_byp_D     (stall_byp_D),
        .rf_waddr_W      (rf_waddr_W),
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
        .stall_cnt       (stall_cnt),
        .byp_cnt         (byp_cnt),
`endif
        .rf_wen_W        (rf_wen_W)
    );

    // Reference pipeline: slot 0 = X (youngest), 1 = M, 2 = W.
    typedef struct {
        bit v;
        bit wen;
        int rd;
        int kind;
    } instr_t;

    typedef struct {
        string       name;
        int          op1;
        int          op2;
        bit          stall;
        bit          wen;
        int          waddr;
        bit [31:0]   scnt;
        bit [31:0]   bcnt;
    } exp_t;

    instr_t    pipe [3];
    bit [31:0] m_stall_cnt;
    bit [31:0] m_byp_cnt;
    exp_t      exp_q [$];
    int        n_checks = 0;
    int        n_errors = 0;

    // Mux encodings indexed by supplying slot: X, M, W, RF.
    int op1_code [4] = '{2, 1, 0, 3};
    int op2_code [4] = '{3, 2, 1, 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_stall_cnt = 0;
        m_byp_cnt   = 0;
    endfunction

    // Which slot supplies a source (3 = regfile) and whether it is not ready yet.
    function automatic void resolve(input int src, input bit en, output int slot, output bit not_ready);
        slot      = 3;
        not_ready = 0;
        if (!en || src == 0) return;
        for (int a = 0; a < 3; a++) begin
            if (pipe[a].v && pipe[a].wen && pipe[a].rd == src) begin
                slot = a;
                if (a == 0 && pipe[a].kind == 1) not_ready = 1;
                if (a == 0 && pipe[a].kind == 2 && !imul_resp_val_X) not_ready = 1;
                return;
            end
        end
    endfunction

    function automatic bit predict_stall();
        int s1, s2;
        bit n1, n2;
        resolve(int'(rs1_D), rs1_en_D, s1, n1);
        resolve(int'(rs2_D), rs2_en_D, s2, n2);
        return val_D && (n1 || n2);
    endfunction

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step(input string name);
        exp_t   e;
        int     s1, s2;
        bit     n1, n2;
        instr_t nx, nm, nw;
        if (!reset) clear_model();
        resolve(int'(rs1_D), rs1_en_D, s1, n1);
        resolve(int'(rs2_D), rs2_en_D, s2, n2);
        e.name  = name;
        e.op1   = op1_code[s1];
        e.op2   = op2_code[s2];
        e.stall = val_D && (n1 || n2);
        e.wen   = pipe[2].v && pipe[2].wen;
        e.waddr = pipe[2].v ? pipe[2].rd : 0;
        e.scnt  = m_stall_cnt;
        e.bcnt  = m_byp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        if (!reset) begin
            clear_model();
        end else begin
            if (e.stall) m_stall_cnt++;
            if (issue_D) m_byp_cnt += 32'((s1 != 3) + (s2 != 3));
            nw = adv_M ? pipe[1] : pipe[2];
            if (!adv_M && adv_W) nw.v = 0;
            nm = (adv_X && !kill_X) ? pipe[0] : pipe[1];
            if (!(adv_X && !kill_X) && adv_M) nm.v = 0;
            nx = pipe[0];
            if (issue_D) nx = '{val_D, rf_wen_D, int'(rd_D), int'(wkind_D)};
            else if (adv_X || kill_X) nx.v = 0;
            pipe[0] = nx;
            pipe[1] = nm;
            pipe[2] = nw;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1; val_D = 0; rs1_D = 0; rs2_D = 0; rs1_en_D = 0; rs2_en_D = 0;
        rd_D = 0; rf_wen_D = 0; wkind_D = 0; issue_D = 0; kill_X = 0;
        adv_X = 0; adv_M = 0; adv_W = 0; imul_resp_val_X = 0;
    endtask

    // Issue an instruction writing rd with the given kind, shifting the pipe along.
    task automatic issue(input string name, input int rd, input int kind);
        val_D = 1; rs1_en_D = 0; rs2_en_D = 0; rd_D = 5'(rd); rf_wen_D = 1;
        wkind_D = 2'(kind); issue_D = 1; adv_X = 1; adv_M = 1; adv_W = 1;
        step(name);
        issue_D = 0; adv_X = 0; adv_M = 0; adv_W = 0;
    endtask

    // Monitor: every DUT cycle is an output beat; pop the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".stall"}, int'(stall_byp_D), int'(e.stall));
                if (!e.stall) begin
                    check({e.name, ".op1_sel"}, int'(op1_byp_sel_D), e.op1);
                    check({e.name, ".op2_sel"}, int'(op2_byp_sel_D), e.op2);
                end
                check({e.name, ".rf_wen_W"}, int'(rf_wen_W), int'(e.wen));
                check({e.name, ".rf_waddr_W"}, int'(rf_waddr_W), e.waddr);
`ifdef LAB2_PROC_SCOREBOARD_STATS_EN
                check({e.name, ".stall_cnt"}, int'(stall_cnt), int'(e.scnt));
                check({e.name, ".byp_cnt"}, int'(byp_cnt), int'(e.bcnt));
`endif
            end
        end
    end

    initial begin
        idle();
        clear_model();
        reset = 0;
        @(posedge clk);
        #1;
        step("reset0");
        step("reset1");
        reset = 1;

        // ALU producer in X bypasses from X.
        issue("addi_x1", 1, 0);
        val_D = 1; rs1_D = 1; rs1_en_D = 1; rd_D = 3;
        step("alu_x_byp");

        // Load-use stall, then bypass from M once the load advances.
        issue("lw_x2", 2, 1);
        val_D = 1; rs1_D = 2; rs2_D = 2; rs1_en_D = 1; rs2_en_D = 1; rd_D = 3; wkind_D = 0;
        step("lw_stall");
        adv_X = 1;
        step("lw_adv");
        adv_X = 0;
        step("lw_m_byp");

        // Multiplier result not yet valid, then valid.
        issue("mul_x4", 4, 2);
        val_D = 1; rs2_D = 4; rs2_en_D = 1; imul_resp_val_X = 0;
        step("mul_stall");
        imul_resp_val_X = 1;
        step("mul_resp");
        imul_resp_val_X = 0;

        // x5 written in both M and W: youngest (M) wins. x0 writer in X ignored.
        issue("x5_a", 5, 0);
        issue("x5_b", 5, 0);
        issue("x0_w", 0, 0);
        val_D = 1; rs1_D = 5; rs1_en_D = 1; rs2_en_D = 0;
        step("x5_m_wins");
        rs1_D = 0;
        step("x0_rf");

        // Kill and issue in the same cycle: killed x6 never reaches M/W.
        issue("x6", 6, 0);
        val_D = 1; rd_D = 8; rf_wen_D = 1; wkind_D = 0; issue_D = 1; kill_X = 1; adv_X = 1;
        adv_M = 1; adv_W = 1; rs1_en_D = 0;
        step("kill_issue");
        kill_X = 0; issue_D = 0;
        rs1_D = 6; rs1_en_D = 1;
        for (int i = 0; i < 3; i++) step("killed_x6");
        adv_X = 0; adv_M = 0; adv_W = 0;

        // Writer x7 reaches W.
        issue("x7", 7, 0);
        val_D = 0; rs1_en_D = 0; adv_X = 1; adv_M = 1;
        step("x7_to_m");
        step("x7_to_w");
        adv_X = 0; adv_M = 0;
        step("x7_in_w");

        // Asynchronous reset with X/M/W populated.
        issue("fill_a", 9, 0);
        issue("fill_b", 10, 2);
        issue("fill_c", 11, 1);
        val_D = 1; rs1_D = 11; rs1_en_D = 1;
        step("stall_before_reset");
        reset = 0;
        step("mid_reset");
        reset = 1;
        step("after_reset");

        // Three stall cycles on a load-use.
        issue("lw_x12", 12, 1);
        val_D = 1; rs1_D = 12; rs1_en_D = 1;
        for (int i = 0; i < 3; i++) step("forced_stall");
        val_D = 0;
        step("stall_count");

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            val_D           = 1'($urandom_range(0, 3) != 0);
            rs1_D           = 5'($urandom_range(0, 7));
            rs2_D           = 5'($urandom_range(0, 7));
            rs1_en_D        = 1'($urandom);
            rs2_en_D        = 1'($urandom);
            rd_D            = 5'($urandom_range(0, 7));
            rf_wen_D        = 1'($urandom_range(0, 3) != 0);
            wkind_D         = 2'($urandom_range(0, 2));
            imul_resp_val_X = 1'($urandom);
            kill_X          = 1'($urandom_range(0, 7) == 0);
            adv_X           = 1'($urandom);
            adv_M           = 1'($urandom);
            adv_W           = 1'($urandom);
            issue_D         = val_D && !predict_stall() && 1'($urandom);
            step("rand");
        end

        idle();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
